riscv_branch_predictor: RTL and testbench
=========================================

# riscv_branch_predictor

Fetch-side dynamic branch predictor: the consumer end of branch resolution. Fetch queries it with a PC and receives a registered taken/target prediction one cycle later. Execute writes back each resolved branch or jump, which trains a table of 2-bit saturating counters and a direct-mapped branch target buffer (BTB). The block also keeps saturating branch and mispredict statistics counters.

## Interface
- XLEN, 64, data/PC width
- BHT_ENTRIES, 64, number of 2-bit counters (power of 2); index = pc[log2(BHT_ENTRIES)+1:2]
- BTB_ENTRIES, 16, number of BTB entries (power of 2); index = pc[log2(BTB_ENTRIES)+1:2]
- TAG_BITS, 16, BTB tag = pc[log2(BTB_ENTRIES)+2 +: TAG_BITS]

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- pred_req_valid  in  1  fetch prediction request
- pred_pc  in  XLEN  PC to predict
- flush  in  1  suppresses the response to this cycle's request
- pred_resp_valid  out  1  response valid, one cycle after the request
- pred_taken  out  1  predicted taken
- pred_hit  out  1  BTB tag hit
- pred_target  out  XLEN  predicted next PC
- upd_valid  in  1  resolution writeback from execute
- upd_pc  in  XLEN  PC of the resolved instruction
- upd_is_branch  in  1  conditional branch
- upd_is_jump  in  1  unconditional jump (JAL/JALR)
- upd_taken  in  1  actual outcome (branch_taken OR jump_taken)
- upd_target  in  XLEN  actual target
- upd_pred_taken  in  1  prediction that was used for this instruction
- upd_pred_target  in  XLEN  predicted target that was used
- stat_branches  out  32  count of resolved branches and jumps; saturates at 0xFFFFFFFF
- stat_mispredicts  out  32  count of mispredicts; saturates at 0xFFFFFFFF

## Operation
- Lookup (combinational on pred_pc, result registered):
  - hit = btb_valid[i] && btb_tag[i] == tag(pred_pc)
  - taken = hit && (btb_is_jump[i] || bht[j][1])
  - target = taken ? btb_target[i] : pred_pc + 4
- Counter update, when upd_valid && upd_is_branch:
  - taken: counter increments, saturating at 2'b11
  - not taken: counter decrements, saturating at 2'b00
- Jumps never modify the BHT.
- BTB write, when upd_valid && upd_taken && (upd_is_branch || upd_is_jump):
  - entry i(upd_pc) is written with valid=1, tag, upd_target and is_jump=upd_is_jump.
  - The write overwrites any aliasing entry.
  - A not-taken branch leaves the BTB unchanged.
- Mispredict = upd_pred_taken != upd_taken, or (upd_taken && upd_pred_target != upd_target).
  - stat_branches increments on each upd_valid with is_branch || is_jump.
  - stat_mispredicts increments when the same condition holds and the instruction mispredicted.
- upd_is_branch and upd_is_jump both high is illegal; the block treats it as a jump.
- upd_valid with neither flag set is ignored entirely.

## Timing
- Reset state:
  - all BHT counters = 2'b01 (weakly not-taken)
  - all BTB valid = 0
  - pred_resp_valid = 0, pred_taken = 0, pred_hit = 0, pred_target = 0
  - stat_branches = 0, stat_mispredicts = 0
- Reset overrides requests and updates in the same cycle.
- Prediction latency is 1 cycle: request in cycle N gives a response in N+1.
  - pred_resp_valid(N+1) = pred_req_valid(N) && !flush(N).
  - Back-to-back requests are accepted every cycle.
- The data outputs update on every cycle with pred_req_valid, even when flushed; consumers qualify them with pred_resp_valid.
- Updates apply at the end of the cycle in which upd_valid is high. flush does not block updates.
- Same cycle lookup and update to the same entry: the lookup sees the pre-update value (read-before-write). The next cycle's lookup sees the new value.
- Stats reflect an update one cycle after upd_valid.

## Test plan
- Cold lookup: reset, then request pc=0x1000.
  - Next cycle: resp_valid=1, taken=0, hit=0, target=0x1004.
- Training:
  - One taken-branch update for pc 0x1000 with target 0x2000, then predict 0x1000: taken=1, hit=1, target=0x2000.
  - Two not-taken updates, then predict: taken=0, hit=1, target=0x1004.
- Saturation: four taken updates for pc 0x1000, then one not-taken update.
  - Prediction stays taken=1 (counter 11→10).
- Jump: jump update for pc 0x3000 with target 0x3800.
  - Predict 0x3000: taken=1, target=0x3800.
  - The BHT counter for 0x3000 is still 01.
- Aliasing and same-cycle update:
  - Predict pc 0x1040 after training 0x1000: hit=0, taken=0, target=0x1044.
  - Predict 0x1000 in the same cycle as its first taken update: taken=0 (old value).
- Flush and stats:
  - Request with flush=1: resp_valid=0 next cycle.
  - Update with pred_taken=0, taken=1 gives stat_branches=1, stat_mispredicts=1.
  - A correctly predicted update gives stat_branches=2, stat_mispredicts=1.

Source files
------------

// File: rtl/riscv_branch_predictor.sv
// Fetch-side dynamic branch predictor: 2-bit saturating counter table (BHT),
// direct-mapped branch target buffer (BTB) and saturating resolution stats.
// Lookups are combinational on pred_pc and registered for a 1-cycle response.
// Updates from execute land at the end of the cycle, so a same-cycle lookup
// observes the pre-update table contents.
module riscv_branch_predictor #(
   parameter int unsigned XLEN        = 64,
   parameter int unsigned BHT_ENTRIES = 64,
   parameter int unsigned BTB_ENTRIES = 16,
   parameter int unsigned TAG_BITS    = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pred_req_valid,
   input  logic [XLEN-1:0] pred_pc,
   input  logic            flush,
   output logic            pred_resp_valid,
   output logic            pred_taken,
   output logic            pred_hit,
   output logic [XLEN-1:0] pred_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_is_branch,
   input  logic            upd_is_jump,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_pred_taken,
   input  logic [XLEN-1:0] upd_pred_target,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
);

   localparam int unsigned BHT_IW = $clog2(BHT_ENTRIES);
   localparam int unsigned BTB_IW = $clog2(BTB_ENTRIES);

   // Table state
   logic [1:0]          bht_q [BHT_ENTRIES];
   logic [1:0]          bht_d [BHT_ENTRIES];
   logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
   logic [BTB_ENTRIES-1:0] btb_jump_q, btb_jump_d;
   logic [TAG_BITS-1:0] btb_tag_q [BTB_ENTRIES];
   logic [XLEN-1:0]     btb_target_q [BTB_ENTRIES];

   // Response registers
   logic            resp_valid_q, resp_valid_d;
   logic            taken_q, taken_d;
   logic            hit_q, hit_d;
   logic [XLEN-1:0] target_q, target_d;

   // Statistics
   logic [31:0] stat_br_q, stat_br_d;
   logic [31:0] stat_mp_q, stat_mp_d;

   // Lookup signals
   logic [BHT_IW-1:0]   rd_bht_idx;
   logic [BTB_IW-1:0]   rd_btb_idx;
   logic [TAG_BITS-1:0] rd_tag;
   logic                lk_hit, lk_taken;
   logic [XLEN-1:0]     lk_target;

   // Update signals
   logic [BHT_IW-1:0]   wr_bht_idx;
   logic [BTB_IW-1:0]   wr_btb_idx;
   logic [TAG_BITS-1:0] wr_tag;
   logic                upd_ctrl, upd_cond_br, btb_we, mispredict;

   // Only the index/tag bit slices of upd_pc are consumed by the tables.
   logic unused_upd_pc;
   assign unused_upd_pc = ^upd_pc;

   assign rd_bht_idx = pred_pc[BHT_IW+1:2];
   assign rd_btb_idx = pred_pc[BTB_IW+1:2];
   assign rd_tag     = pred_pc[BTB_IW+2 +: TAG_BITS];
   assign wr_bht_idx = upd_pc[BHT_IW+1:2];
   assign wr_btb_idx = upd_pc[BTB_IW+1:2];
   assign wr_tag     = upd_pc[BTB_IW+2 +: TAG_BITS];

   // Combinational lookup against the current (pre-update) tables
   always_comb begin
      lk_hit    = btb_valid_q[rd_btb_idx] && (btb_tag_q[rd_btb_idx] == rd_tag);
      lk_taken  = lk_hit && (btb_jump_q[rd_btb_idx] || bht_q[rd_bht_idx][1]);
      lk_target = lk_taken ? btb_target_q[rd_btb_idx] : pred_pc + XLEN'(4);
   end

   // Response next-state: data follows every request, valid is flush-qualified
   always_comb begin
      resp_valid_d = pred_req_valid && !flush;
      taken_d      = taken_q;
      hit_d        = hit_q;
      target_d     = target_q;
      if (pred_req_valid) begin
         taken_d  = lk_taken;
         hit_d    = lk_hit;
         target_d = lk_target;
      end
   end

   // Resolution decode; both flags set is treated as a jump (no BHT training)
   always_comb begin
      upd_ctrl    = upd_valid && (upd_is_branch || upd_is_jump);
      upd_cond_br = upd_valid && upd_is_branch && !upd_is_jump;
      btb_we      = upd_ctrl && upd_taken;
      mispredict  = (upd_pred_taken != upd_taken) ||
                    (upd_taken && (upd_pred_target != upd_target));
   end

   // BHT counter and BTB valid/type next-state
   always_comb begin
      bht_d       = bht_q;
      btb_valid_d = btb_valid_q;
      btb_jump_d  = btb_jump_q;
      if (upd_cond_br) begin
         if (upd_taken) begin
            if (bht_q[wr_bht_idx] != 2'b11) bht_d[wr_bht_idx] = bht_q[wr_bht_idx] + 2'd1;
         end else begin
            if (bht_q[wr_bht_idx] != 2'b00) bht_d[wr_bht_idx] = bht_q[wr_bht_idx] - 2'd1;
         end
      end
      if (btb_we) begin
         btb_valid_d[wr_btb_idx] = 1'b1;
         btb_jump_d[wr_btb_idx]  = upd_is_jump;
      end
   end

   // Saturating statistics next-state
   always_comb begin
      stat_br_d = stat_br_q;
      stat_mp_d = stat_mp_q;
      if (upd_ctrl) begin
         if (stat_br_q != '1) stat_br_d = stat_br_q + 32'd1;
         if (mispredict && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + 32'd1;
      end
   end

   // Resettable state: counters, BTB valid bits, response and stats
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
         btb_valid_q  <= '0;
         btb_jump_q   <= '0;
         resp_valid_q <= 1'b0;
         taken_q      <= 1'b0;
         hit_q        <= 1'b0;
         target_q     <= '0;
         stat_br_q    <= '0;
         stat_mp_q    <= '0;
      end else begin
         bht_q        <= bht_d;
         btb_valid_q  <= btb_valid_d;
         btb_jump_q   <= btb_jump_d;
         resp_valid_q <= resp_valid_d;
         taken_q      <= taken_d;
         hit_q        <= hit_d;
         target_q     <= target_d;
         stat_br_q    <= stat_br_d;
         stat_mp_q    <= stat_mp_d;
      end
   end

   // BTB payload, qualified by the valid bits so it needs no reset
   always_ff @(posedge clk) begin
      if (!rst && btb_we) begin
         btb_tag_q[wr_btb_idx]    <= wr_tag;
         btb_target_q[wr_btb_idx] <= upd_target;
      end
   end

   assign pred_resp_valid  = resp_valid_q;
   assign pred_taken       = taken_q;
   assign pred_hit         = hit_q;
   assign pred_target      = target_q;
   assign stat_branches    = stat_br_q;
   assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_riscv_branch_predictor.sv
// Directed self-checking bench for riscv_branch_predictor.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_riscv_branch_predictor;

   logic        clk;
   logic        rst;
   logic        pred_req_valid;
   logic [63:0] pred_pc;
   logic        flush;
   logic        pred_resp_valid;
   logic        pred_taken;
   logic        pred_hit;
   logic [63:0] pred_target;
   logic        upd_valid;
   logic [63:0] upd_pc;
   logic        upd_is_branch;
   logic        upd_is_jump;
   logic        upd_taken;
   logic [63:0] upd_target;
   logic        upd_pred_taken;
   logic [63:0] upd_pred_target;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   int errors = 0;
   int checks = 0;

   riscv_branch_predictor #(
      .XLEN(64), .BHT_ENTRIES(64), .BTB_ENTRIES(16), .TAG_BITS(16)
   ) dut (
      .clk(clk), .rst(rst),
      .pred_req_valid(pred_req_valid), .pred_pc(pred_pc), .flush(flush),
      .pred_resp_valid(pred_resp_valid), .pred_taken(pred_taken),
      .pred_hit(pred_hit), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_is_branch(upd_is_branch), .upd_is_jump(upd_is_jump),
      .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
      .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic clear_inputs();
      pred_req_valid  = 1'b0;
      pred_pc         = '0;
      flush           = 1'b0;
      upd_valid       = 1'b0;
      upd_pc          = '0;
      upd_is_branch   = 1'b0;
      upd_is_jump     = 1'b0;
      upd_taken       = 1'b0;
      upd_target      = '0;
      upd_pred_taken  = 1'b0;
      upd_pred_target = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_update(input logic [63:0] pc, input logic br, input logic jmp,
                             input logic tk, input logic [63:0] tgt,
                             input logic ptk, input logic [63:0] ptgt);
      upd_valid       = 1'b1;
      upd_pc          = pc;
      upd_is_branch   = br;
      upd_is_jump     = jmp;
      upd_taken       = tk;
      upd_target      = tgt;
      upd_pred_taken  = ptk;
      upd_pred_target = ptgt;
   endtask

   // One-cycle update with no concurrent request
   task automatic do_update(input logic [63:0] pc, input logic br, input logic jmp,
                            input logic tk, input logic [63:0] tgt);
      set_update(pc, br, jmp, tk, tgt, 1'b0, '0);
      @(negedge clk);
      clear_inputs();
   endtask

   // One-cycle request; response is visible on return
   task automatic do_predict(input logic [63:0] pc, input logic fl);
      pred_req_valid = 1'b1;
      pred_pc        = pc;
      flush          = fl;
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pred_req_valid = 1'b1;
      pred_pc = 64'h1000;
      set_update(64'h1000, 1'b1, 1'b0, 1'b1, 64'h2000, 1'b0, 64'h0);
      @(negedge clk);
      @(negedge clk);
      checks++; if (pred_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", pred_resp_valid); end
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b want 0", pred_taken); end
      checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", pred_hit); end
      checks++; if (pred_target !== 64'h0) begin errors++; $display("FAIL reset_target: got %h want 0", pred_target); end
      checks++; if (stat_branches !== 32'd0) begin errors++; $display("FAIL reset_stat_br: got %0d want 0", stat_branches); end
      checks++; if (stat_mispredicts !== 32'd0) begin errors++; $display("FAIL reset_stat_mp: got %0d want 0", stat_mispredicts); end
      clear_inputs();
      rst = 1'b0;
      // The update held during reset must not have trained anything
      do_predict(64'h1000, 1'b0);
      checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL reset_blocks_update: hit got %b want 0", pred_hit); end
   endtask

   task automatic test_cold();
      do_reset();
      do_predict(64'h1000, 1'b0);
      checks++; if (pred_resp_valid !== 1'b1) begin errors++; $display("FAIL cold_valid: got %b want 1", pred_resp_valid); end
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL cold_taken: got %b want 0", pred_taken); end
      checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL cold_hit: got %b want 0", pred_hit); end
      checks++; if (pred_target !== 64'h1004) begin errors++; $display("FAIL cold_target: got %h want 1004", pred_target); end
      @(negedge clk);
      checks++; if (pred_resp_valid !== 1'b0) begin errors++; $display("FAIL cold_valid_drop: got %b want 0", pred_resp_valid); end
   endtask

   task automatic test_training();
      do_reset();
      do_update(64'h1000, 1'b1, 1'b0, 1'b1, 64'h2000);   // 01 -> 10
      do_predict(64'h1000, 1'b0);
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL train_taken: got %b want 1", pred_taken); end
      checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL train_hit: got %b want 1", pred_hit); end
      checks++; if (pred_target !== 64'h2000) begin errors++; $display("FAIL train_target: got %h want 2000", pred_target); end
      do_update(64'h1000, 1'b1, 1'b0, 1'b0, 64'h0);      // 10 -> 01
      do_update(64'h1000, 1'b1, 1'b0, 1'b0, 64'h0);      // 01 -> 00
      do_predict(64'h1000, 1'b0);
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL untrain_taken: got %b want 0", pred_taken); end
      checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL untrain_hit: got %b want 1", pred_hit); end
      checks++; if (pred_target !== 64'h1004) begin errors++; $display("FAIL untrain_target: got %h want 1004", pred_target); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 4; i++) do_update(64'h1000, 1'b1, 1'b0, 1'b1, 64'h2000); // -> 11
      do_update(64'h1000, 1'b1, 1'b0, 1'b0, 64'h0);      // 11 -> 10
      do_predict(64'h1000, 1'b0);
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_hi_taken: got %b want 1", pred_taken); end
      checks++; if (pred_target !== 64'h2000) begin errors++; $display("FAIL sat_hi_target: got %h want 2000", pred_target); end
      do_update(64'h1000, 1'b1, 1'b0, 1'b0, 64'h0);      // 10 -> 01
      do_predict(64'h1000, 1'b0);
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_step_taken: got %b want 0", pred_taken); end
      // Floor: three not-taken from 01 stays at 00, one taken gives 01
      for (int i = 0; i < 3; i++) do_update(64'h1000, 1'b1, 1'b0, 1'b0, 64'h0);
      do_update(64'h1000, 1'b1, 1'b0, 1'b1, 64'h2000);   // 00 -> 01
      do_predict(64'h1000, 1'b0);
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_lo_taken: got %b want 0", pred_taken); end
      do_update(64'h1000, 1'b1, 1'b0, 1'b1, 64'h2000);   // 01 -> 10
      do_predict(64'h1000, 1'b0);
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_lo_recover: got %b want 1", pred_taken); end
   endtask

   task automatic test_jump();
      do_reset();
      do_update(64'h3000, 1'b0, 1'b1, 1'b1, 64'h3800);
      do_predict(64'h3000, 1'b0);
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jump_taken: got %b want 1", pred_taken); end
      checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL jump_hit: got %b want 1", pred_hit); end
      checks++; if (pred_target !== 64'h3800) begin errors++; $display("FAIL jump_target: got %h want 3800", pred_target); end
      // Counter still 01: taken (->10) then not-taken (->01) predicts not-taken
      do_update(64'h3000, 1'b1, 1'b0, 1'b1, 64'h3800);
      do_update(64'h3000, 1'b1, 1'b0, 1'b0, 64'h0);
      do_predict(64'h3000, 1'b0);
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL jump_bht_untouched: got %b want 0", pred_taken); end
      checks++; if (pred_target !== 64'h3004) begin errors++; $display("FAIL jump_bht_target: got %h want 3004", pred_target); end
   endtask

   task automatic test_illegal_flags();
      do_reset();
      do_update(64'h3000, 1'b1, 1'b1, 1'b1, 64'h3800);   // treated as jump
      do_predict(64'h3000, 1'b0);
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL both_flags_taken: got %b want 1", pred_taken); end
      do_update(64'h3000, 1'b1, 1'b0, 1'b1, 64'h3800);
      do_update(64'h3000, 1'b1, 1'b0, 1'b0, 64'h0);
      do_predict(64'h3000, 1'b0);
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL both_flags_bht: got %b want 0", pred_taken); end
      checks++; if (stat_branches !== 32'd3) begin errors++; $display("FAIL both_flags_stat: got %0d want 3", stat_branches); end
      // Neither flag: ignored entirely
      do_update(64'h5000, 1'b0, 1'b0, 1'b1, 64'h5800);
      do_predict(64'h5000, 1'b0);
      checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL noflag_hit: got %b want 0", pred_hit); end
      checks++; if (stat_branches !== 32'd3) begin errors++; $display("FAIL noflag_stat: got %0d want 3", stat_branches); end
   endtask

   task automatic test_alias();
      do_reset();
      // Lookup in the same cycle as the first taken update sees old state
      pred_req_valid = 1'b1;
      pred_pc        = 64'h1000;
      set_update(64'h1000, 1'b1, 1'b0, 1'b1, 64'h2000, 1'b0, 64'h0);
      @(negedge clk);
      clear_inputs();
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rbw_taken: got %b want 0", pred_taken); end
      checks++; if (pred_target !== 64'h1004) begin errors++; $display("FAIL rbw_target: got %h want 1004", pred_target); end
      do_predict(64'h1000, 1'b0);
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL rbw_next_taken: got %b want 1", pred_taken); end
      do_predict(64'h1040, 1'b0);
      checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL alias_hit: got %b want 0", pred_hit); end
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_taken: got %b want 0", pred_taken); end
      checks++; if (pred_target !== 64'h1044) begin errors++; $display("FAIL alias_target: got %h want 1044", pred_target); end
      // Aliasing write overwrites the 0x1000 entry
      do_update(64'h1040, 1'b1, 1'b0, 1'b1, 64'h4000);
      do_predict(64'h1000, 1'b0);
      checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL alias_evict_hit: got %b want 0", pred_hit); end
      do_predict(64'h1040, 1'b0);
      checks++; if (pred_target !== 64'h4000) begin errors++; $display("FAIL alias_new_target: got %h want 4000", pred_target); end
   endtask

   task automatic test_flush_stats();
      do_reset();
      do_predict(64'h1000, 1'b1);
      checks++; if (pred_resp_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", pred_resp_valid); end
      checks++; if (pred_target !== 64'h1004) begin errors++; $display("FAIL flush_data: got %h want 1004", pred_target); end
      set_update(64'h1000, 1'b1, 1'b0, 1'b1, 64'h2000, 1'b0, 64'h1004); @(negedge clk); clear_inputs();
      checks++; if (stat_branches !== 32'd1) begin errors++; $display("FAIL stat_mp1_br: got %0d want 1", stat_branches); end
      checks++; if (stat_mispredicts !== 32'd1) begin errors++; $display("FAIL stat_mp1_mp: got %0d want 1", stat_mispredicts); end
      set_update(64'h1000, 1'b1, 1'b0, 1'b1, 64'h2000, 1'b1, 64'h2000); @(negedge clk); clear_inputs();
      checks++; if (stat_branches !== 32'd2) begin errors++; $display("FAIL stat_ok_br: got %0d want 2", stat_branches); end
      checks++; if (stat_mispredicts !== 32'd1) begin errors++; $display("FAIL stat_ok_mp: got %0d want 1", stat_mispredicts); end
      set_update(64'h1000, 1'b1, 1'b0, 1'b1, 64'h2000, 1'b1, 64'h2004); @(negedge clk); clear_inputs();
      checks++; if (stat_mispredicts !== 32'd2) begin errors++; $display("FAIL stat_tgt_mp: got %0d want 2", stat_mispredicts); end
      set_update(64'h1000, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h1234); @(negedge clk); clear_inputs();
      checks++; if (stat_branches !== 32'd4) begin errors++; $display("FAIL stat_nt_br: got %0d want 4", stat_branches); end
      checks++; if (stat_mispredicts !== 32'd2) begin errors++; $display("FAIL stat_nt_mp: got %0d want 2", stat_mispredicts); end
      // flush does not block an update
      pred_req_valid = 1'b1; pred_pc = 64'h1000; flush = 1'b1;
      set_update(64'h1000, 1'b0, 1'b1, 1'b1, 64'h2000, 1'b0, 64'h0); @(negedge clk); clear_inputs();
      checks++; if (stat_branches !== 32'd5) begin errors++; $display("FAIL flush_upd_br: got %0d want 5", stat_branches); end
      checks++; if (stat_mispredicts !== 32'd3) begin errors++; $display("FAIL flush_upd_mp: got %0d want 3", stat_mispredicts); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      do_update(64'h1000, 1'b1, 1'b0, 1'b1, 64'h2000);
      pred_req_valid = 1'b1; pred_pc = 64'h1000;
      @(negedge clk);
      pred_pc = 64'h1040;
      checks++; if (pred_target !== 64'h2000 || pred_resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_0: got %h/%b want 2000/1", pred_target, pred_resp_valid); end
      @(negedge clk);
      pred_pc = 64'h1000; flush = 1'b1;
      checks++; if (pred_target !== 64'h1044 || pred_resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_1: got %h/%b want 1044/1", pred_target, pred_resp_valid); end
      @(negedge clk);
      clear_inputs();
      checks++; if (pred_target !== 64'h2000 || pred_resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_2: got %h/%b want 2000/0", pred_target, pred_resp_valid); end
      @(negedge clk);
      checks++; if (pred_target !== 64'h2000 || pred_resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_hold: got %h/%b want 2000/0", pred_target, pred_resp_valid); end
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      test_reset();
      test_cold();
      test_training();
      test_saturation();
      test_jump();
      test_illegal_flags();
      test_alias();
      test_flush_stats();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
